// File: rtl/ddr_cmd_prefetch_fifo_pkg.sv
// Shared constants and sizing helpers for the DDR command prefetch FIFO.
package ddr_cmd_prefetch_fifo_pkg;

  localparam logic RST_ASSERT = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int fifo_cap(input int depth_w);
    return 1 << depth_w;
  endfunction

  // Two entries live in the prefetch stage, so the RAM is short by two.
  function automatic int ram_depth(input int depth_w);
    return fifo_cap(depth_w) - 2;
  endfunction

endpackage

// File: rtl/ddr_fifo_sdp_ram.sv
// Simple-dual-port RAM with one write port and a registered read port.
module ddr_fifo_sdp_ram
  import ddr_cmd_prefetch_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 14,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ddr_cmd_prefetch_fifo.sv
// FWFT command/address FIFO: SDP RAM backed by a 2-entry prefetch (out + skid),
// with occupancy, almost flags, synchronous flush and sticky error flags.
module ddr_cmd_prefetch_fifo
  import ddr_cmd_prefetch_fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH_W  = 9,
  parameter int AF_LEVEL = (1 << DEPTH_W) - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wr_en,
  output logic               wr_vld,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               rd_en,
  output logic               rd_vld,
  output logic [DATA_W-1:0]  rd_data,
  output logic [DEPTH_W:0]   level,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               overflow,
  output logic               underflow
);

  localparam int N     = fifo_cap(DEPTH_W);
  localparam int RAM_D = ram_depth(DEPTH_W);
  localparam int LW    = DEPTH_W + 1;
  localparam logic [LW-1:0]      N_L      = LW'(N);
  localparam logic [LW-1:0]      AF_L     = LW'(AF_LEVEL);
  localparam logic [LW-1:0]      AE_L     = LW'(AE_LEVEL);
  localparam logic [DEPTH_W-1:0] PTR_LAST = DEPTH_W'(RAM_D - 1);

  if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= N) || DEPTH_W < 4 || DEPTH_W > 20)
  begin : g_param_err
    $error("ddr_cmd_prefetch_fifo: need AE_LEVEL < AF_LEVEL <= 2**DEPTH_W, DEPTH_W in 4..20");
  end

  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt_q, ram_cnt_d;
  logic [LW-1:0]      level_q, level_d;
  logic               out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, infl_q, infl_d;
  logic [DATA_W-1:0]  out_q, out_d, skid_q, skid_d;
  logic               wr_vld_q, wr_vld_d, af_q, af_d, ae_q, ae_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;

  logic               wr_acc, pop, bypass, ram_we, ram_re, in_vld;
  logic [1:0]         pf_left;
  logic [DATA_W-1:0]  in_data, ram_rdata;

  ddr_fifo_sdp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (RAM_D),
    .AW    (DEPTH_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .re   (ram_re),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;

    wr_acc  = wr_en & wr_vld_q;
    pop     = rd_en & out_vld_q;
    pf_left = 2'(out_vld_q) + 2'(skid_vld_q) - 2'(pop);

    // Bypass only when nothing older sits in RAM or in the read pipe.
    bypass = wr_acc && (ram_cnt_q == '0) && !infl_q && (pf_left < 2'd2);
    ram_we = wr_acc && !bypass;
    ram_re = (ram_cnt_q != '0) && ((pf_left + 2'(infl_q)) < 2'd2);

    if (pop) begin
      out_vld_d  = skid_vld_q;
      out_d      = skid_q;
      skid_vld_d = 1'b0;
    end

    in_vld  = infl_q | bypass;
    in_data = infl_q ? ram_rdata : wr_data;
    if (in_vld) begin
      if (!out_vld_d) begin
        out_vld_d = 1'b1;
        out_d     = in_data;
      end else begin
        skid_vld_d = 1'b1;
        skid_d     = in_data;
      end
    end

    infl_d = ram_re;
    if (ram_we) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + DEPTH_W'(1);
    if (ram_re) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + DEPTH_W'(1);
    ram_cnt_d = ram_cnt_q + DEPTH_W'(ram_we) - DEPTH_W'(ram_re);
    level_d   = level_q + LW'(wr_acc) - LW'(pop);

    ovf_d = ovf_q | (wr_en & ~wr_vld_q);
    unf_d = unf_q | (rd_en & ~out_vld_q);

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      level_d    = '0;
      out_vld_d  = 1'b0;
      out_d      = '0;
      skid_vld_d = 1'b0;
      skid_d     = '0;
      infl_d     = 1'b0;
    end

    wr_vld_d = level_d < N_L;
    af_d     = level_d >= AF_L;
    ae_d     = level_d <= AE_L;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERT) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      level_q    <= '0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      infl_q     <= 1'b0;
      wr_vld_q   <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      level_q    <= level_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      infl_q     <= infl_d;
      wr_vld_q   <= wr_vld_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign wr_vld       = wr_vld_q;
  assign rd_vld       = out_vld_q;
  assign rd_data      = out_q;
  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
